perf_counter_bank: RTL and testbench
====================================

Name: perf_counter_bank

Overview:
Parametrised hardware performance-monitor bank attached beside Pipeline_top. It generalises the fixed cycle and retired-instruction counters into a configurable set of counters:
- counter 0 counts cycles;
- counter 1 counts retired instructions, accepting multi-retire per cycle;
- counters 2..NUM_CNT-1 count generic pipeline events (stalls, flushes, branch mispredicts, ...).

It adds global enable, preset/clear, atomic snapshot, a wrap or saturate mode, and sticky overflow flags with a maskable interrupt. Software and benches read counters through a registered read port, so the bench no longer probes DUT internals hierarchically.

Parameters:
- NUM_EVT, 4, number of generic event inputs.
- CNT_W, 32, width of every counter.
- RET_W, 2, width of the per-cycle retire-count input (0..2^RET_W-1 instructions per cycle).
- SAT_MODE, 0, 0 = counters wrap, 1 = counters saturate at all-ones.
- Derived: NUM_CNT = NUM_EVT+2; AW = clog2(NUM_CNT).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- en_i  in  1  global count enable.
- retire_i  in  RET_W  instructions retired this cycle.
- evt_i  in  NUM_EVT  one-cycle event pulses; bit k drives counter k+2.
- clr_i  in  1  synchronous clear of all counters and overflow flags.
- snap_i  in  1  copy all live counters into shadow registers.
- wr_en_i  in  1  preset strobe.
- wr_addr_i  in  AW  counter index to preset.
- wr_data_i  in  CNT_W  preset value.
- rd_en_i  in  1  read request.
- rd_addr_i  in  AW  counter index to read.
- rd_live_i  in  1  1 = read the live counter, 0 = read the shadow.
- rd_data_o  out  CNT_W  read data.
- rd_valid_o  out  1  read-data valid.
- ovf_o  out  NUM_CNT  sticky overflow flags.
- ovf_mask_i  in  NUM_CNT  interrupt enable per counter.
- irq_o  out  1  OR of (ovf_o AND ovf_mask_i), registered.

Behaviour:
- Reset (rst=0, asynchronous): all live counters, shadows, rd_data_o, rd_valid_o, ovf_o and irq_o go to 0.
- Increment amounts, applied only when en_i=1:
  - counter 0 increments by 1 every cycle;
  - counter 1 increments by retire_i, zero-extended;
  - counter k+2 increments by 1 when evt_i[k]=1.
- en_i=0 freezes all counters. Presets, clears, snapshots and reads still operate.
- Wrap mode (SAT_MODE=0): sum taken modulo 2^CNT_W. The carry-out sets ovf_o[i].
- Saturate mode (SAT_MODE=1): counter holds at 2^CNT_W-1. A carry-out sets ovf_o[i]. Once saturated, further increments change nothing.
- Per-counter priority in one cycle: clr_i > preset (wr_en_i with matching wr_addr_i) > increment.
  - A preset loads wr_data_i exactly; that cycle's increment is dropped.
  - A preset also clears ovf_o of that index.
- wr_addr_i or rd_addr_i >= NUM_CNT:
  - a write is ignored;
  - a read returns 0 with rd_valid_o=1.
- Snapshot: when snap_i=1, each shadow captures the live value before that cycle's update (pre-clear, pre-preset, pre-increment). All shadows are captured atomically in the same edge.
- Read:
  - Latency is 1 cycle: rd_valid_o=1 and rd_data_o are valid on the cycle after rd_en_i.
  - With rd_live_i=1, the read returns the live value as of the request edge (pre-update).
  - rd_data_o holds its last value while rd_valid_o=0.
  - Back-to-back reads are allowed, one per cycle.
- Overflow flags: sticky until clr_i or a preset of that index. If an overflow and a clearing action occur in the same cycle, the clear wins.
- irq_o is registered, so it rises 1 cycle after the ovf_o/mask condition becomes true.
- Reset asserted mid-operation: everything returns to 0 immediately. The first count occurs on the first clock edge with rst=1 and en_i=1.

Decomposition:
- Package perf_pkg holds:
  - counter index constants: CNT_CYCLE=0, CNT_INSTRET=1, CNT_EVT0=2;
  - the default parameter values;
  - a function that computes AW.
- Sub-module perf_counter_cell implements one counter:
  - inputs: inc amount, load, load value, clr, en;
  - parameter: SAT_MODE;
  - outputs: value and ovf-set pulse.
- perf_counter_bank instantiates NUM_CNT cells in a generate loop and adds the shadow registers, read mux and irq logic.

Test Plan:
- Basic counting: reset low for 1 cycle, then en_i=1 for 40 cycles with retire_i=1 every cycle and evt_i[0] pulsed 5 times -> read live counters 0/1/2 returns 40/40/5; rd_valid_o is high exactly 1 cycle after each rd_en_i.
- Multi-retire: retire_i=2 for 10 cycles, then 3 for 10 cycles -> counter 1 = 50, counter 0 = 20; CPI check 20/50 = 0.4.
- Wrap overflow (CNT_W=8, SAT_MODE=0): preset counter 0 to 8'hFD, run 4 cycles -> value 8'h01, ovf_o[0]=1; with ovf_mask_i[0]=1, irq_o rises 1 cycle after ovf_o[0].
- Saturate (SAT_MODE=1, CNT_W=8): preset 8'hFE, run 5 cycles -> value holds at 8'hFF, ovf_o[0]=1; a preset to 0 clears ovf_o[0] and irq_o.
- Priority and snapshot: in the same cycle assert snap_i, preset counter 2 to 100, and pulse evt_i[0] with counter 2 = 7 -> shadow[2]=7, live[2]=100; the next cycle, clr_i together with evt_i -> all live counters 0, all ovf_o 0, shadows unchanged.
- Freeze and async reset: en_i=0 for 10 cycles -> no counter changes; asserting rst mid-cycle -> all outputs 0 before the next edge; out-of-range rd_addr_i -> rd_data_o=0, rd_valid_o=1.

Source files
------------

// File: rtl/perf_pkg.sv
// perf_pkg: shared constants for the performance-counter bank.
//   - Fixed counter indices: cycle counter, retired-instruction counter and
//     the first generic event counter.
//   - Default parameter values used by perf_counter_bank / perf_counter_cell.
//   - calc_aw(): address width needed to index a given number of counters.
package perf_pkg;

  localparam int CNT_CYCLE   = 0;
  localparam int CNT_INSTRET = 1;
  localparam int CNT_EVT0    = 2;

  localparam int DEF_NUM_EVT  = 4;
  localparam int DEF_CNT_W    = 32;
  localparam int DEF_RET_W    = 2;
  localparam int DEF_SAT_MODE = 0;

  // Never returns 0 so that address ports always have at least one bit.
  function automatic int calc_aw(input int num_cnt);
    return (num_cnt <= 2) ? 1 : $clog2(num_cnt);
  endfunction

endpackage

// File: rtl/perf_counter_cell.sv
// perf_counter_cell: one performance counter.
//   clk      - clock
//   rst      - asynchronous active-low reset
//   en       - count enable
//   inc      - increment amount for this cycle
//   load     - preset strobe (loads load_val, drops this cycle's increment)
//   load_val - preset value
//   clr      - synchronous clear (highest priority)
//   value    - current counter value
//   ovf_set  - high in a cycle whose increment carries out of the counter
//              (never high together with load or clr)
module perf_counter_cell
  import perf_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SAT_MODE = DEF_SAT_MODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [CNT_W-1:0] inc,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             clr,
  output logic [CNT_W-1:0] value,
  output logic             ovf_set
);

  localparam bit SAT = (SAT_MODE != 0);

  logic [CNT_W-1:0] value_reg;
  logic [CNT_W-1:0] value_next;
  logic [CNT_W:0]   sum;
  logic             carry;

  always_comb begin
    sum        = {1'b0, value_reg} + {1'b0, inc};
    carry      = sum[CNT_W];
    value_next = value_reg;
    ovf_set    = 1'b0;
    if (clr) begin
      value_next = '0;
    end else if (load) begin
      value_next = load_val;
    end else if (en) begin
      ovf_set = carry;
      // A saturated counter keeps all-ones; any further carry stays pinned.
      if (carry && SAT) begin
        value_next = '1;
      end else begin
        value_next = sum[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_reg <= '0;
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: configurable hardware performance-monitor bank.
//   clk        - clock
//   rst        - asynchronous active-low reset
//   en_i       - global count enable
//   retire_i   - instructions retired this cycle (feeds counter 1)
//   evt_i      - event pulses, bit k feeds counter k+2
//   clr_i      - clear all counters and overflow flags
//   snap_i     - copy all live counters into the shadow registers
//   wr_en_i / wr_addr_i / wr_data_i - preset one counter
//   rd_en_i / rd_addr_i / rd_live_i - read request (live or shadow)
//   rd_data_o / rd_valid_o          - read response, one cycle later
//   ovf_o      - sticky overflow flags
//   ovf_mask_i - per-counter interrupt enable
//   irq_o      - registered OR of (ovf_o & ovf_mask_i)
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int  NUM_EVT  = DEF_NUM_EVT,
  parameter int  CNT_W    = DEF_CNT_W,
  parameter int  RET_W    = DEF_RET_W,
  parameter int  SAT_MODE = DEF_SAT_MODE,
  localparam int NUM_CNT  = NUM_EVT + 2,
  localparam int AW       = calc_aw(NUM_EVT + 2)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic [RET_W-1:0]   retire_i,
  input  logic [NUM_EVT-1:0] evt_i,
  input  logic               clr_i,
  input  logic               snap_i,
  input  logic               wr_en_i,
  input  logic [AW-1:0]      wr_addr_i,
  input  logic [CNT_W-1:0]   wr_data_i,
  input  logic               rd_en_i,
  input  logic [AW-1:0]      rd_addr_i,
  input  logic               rd_live_i,
  output logic [CNT_W-1:0]   rd_data_o,
  output logic               rd_valid_o,
  output logic [NUM_CNT-1:0] ovf_o,
  input  logic [NUM_CNT-1:0] ovf_mask_i,
  output logic               irq_o
);

  // One extra bit so NUM_CNT itself is representable when it is a power of 2.
  localparam logic [AW:0] CNT_LIM = NUM_CNT[AW:0];

  logic [CNT_W-1:0]   inc_amt    [NUM_CNT];
  logic [CNT_W-1:0]   live_val   [NUM_CNT];
  logic [CNT_W-1:0]   shadow_reg [NUM_CNT];
  logic [NUM_CNT-1:0] load_vec;
  logic [NUM_CNT-1:0] ovf_set_vec;
  logic [NUM_CNT-1:0] ovf_reg;
  logic               irq_reg;
  logic [CNT_W-1:0]   rd_data_reg;
  logic               rd_valid_reg;
  logic               wr_hit;
  logic               rd_hit;

  // Out-of-range addresses never match a cell, so such writes vanish.
  assign wr_hit = wr_en_i && ({1'b0, wr_addr_i} < CNT_LIM);
  assign rd_hit = ({1'b0, rd_addr_i} < CNT_LIM);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CNT; gi++) begin : g_cell
      if (gi == CNT_CYCLE) begin : g_inc_cycle
        assign inc_amt[gi] = CNT_W'(1);
      end else if (gi == CNT_INSTRET) begin : g_inc_ret
        assign inc_amt[gi] = CNT_W'(retire_i);
      end else begin : g_inc_evt
        assign inc_amt[gi] = CNT_W'(evt_i[gi-CNT_EVT0]);
      end

      assign load_vec[gi] = wr_hit && (wr_addr_i == AW'(gi));

      perf_counter_cell #(
        .CNT_W   (CNT_W),
        .SAT_MODE(SAT_MODE)
      ) u_cell (
        .clk     (clk),
        .rst     (rst),
        .en      (en_i),
        .inc     (inc_amt[gi]),
        .load    (load_vec[gi]),
        .load_val(wr_data_i),
        .clr     (clr_i),
        .value   (live_val[gi]),
        .ovf_set (ovf_set_vec[gi])
      );
    end
  endgenerate

  // Shadows sample the live values as they stand before this edge's update,
  // which gives an atomic snapshot across the whole bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_reg[i] <= '0;
      end
    end else if (snap_i) begin
      for (int i = 0; i < NUM_CNT; i++) begin
        shadow_reg[i] <= live_val[i];
      end
    end
  end

  // Overflow flags: ovf_set is already suppressed by the cell on clr/load,
  // and the load mask clears a preset counter's sticky flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_reg <= '0;
      irq_reg <= 1'b0;
    end else begin
      if (clr_i) begin
        ovf_reg <= '0;
      end else begin
        ovf_reg <= (ovf_reg | ovf_set_vec) & ~load_vec;
      end
      irq_reg <= |(ovf_reg & ovf_mask_i);
    end
  end

  // Registered read port; data holds between reads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_reg  <= '0;
      rd_valid_reg <= 1'b0;
    end else begin
      rd_valid_reg <= rd_en_i;
      if (rd_en_i) begin
        if (!rd_hit) begin
          rd_data_reg <= '0;
        end else if (rd_live_i) begin
          rd_data_reg <= live_val[rd_addr_i];
        end else begin
          rd_data_reg <= shadow_reg[rd_addr_i];
        end
      end
    end
  end

  assign rd_data_o  = rd_data_reg;
  assign rd_valid_o = rd_valid_reg;
  assign ovf_o      = ovf_reg;
  assign irq_o      = irq_reg;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: two 8-bit instances (wrap and saturate)
// driven by identical stimulus; read results go through a scoreboard queue.
module tb_perf_counter_bank;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] retire;
  logic [3:0] evt;
  logic       clr;
  logic       snap;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic       rd_live;
  logic [5:0] ovf_mask;

  logic [7:0] rd_data_w, rd_data_s;
  logic       rd_valid_w, rd_valid_s;
  logic [5:0] ovf_w, ovf_s;
  logic       irq_w, irq_s;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] exp_w_q[$];
  logic [7:0] exp_s_q[$];
  logic [7:0] obs_q[$];
  logic       rd_en_prev;

  perf_counter_bank #(.NUM_EVT(4), .CNT_W(8), .RET_W(2), .SAT_MODE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en_i(en), .retire_i(retire), .evt_i(evt),
    .clr_i(clr), .snap_i(snap), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_live_i(rd_live), .rd_data_o(rd_data_w), .rd_valid_o(rd_valid_w),
    .ovf_o(ovf_w), .ovf_mask_i(ovf_mask), .irq_o(irq_w)
  );

  perf_counter_bank #(.NUM_EVT(4), .CNT_W(8), .RET_W(2), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst(rst), .en_i(en), .retire_i(retire), .evt_i(evt),
    .clr_i(clr), .snap_i(snap), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .rd_en_i(rd_en), .rd_addr_i(rd_addr),
    .rd_live_i(rd_live), .rd_data_o(rd_data_s), .rd_valid_o(rd_valid_s),
    .ovf_o(ovf_s), .ovf_mask_i(ovf_mask), .irq_o(irq_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_preset(input logic [2:0] addr, input logic [7:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] addr, input logic live,
                         input logic [7:0] exp_w, input logic [7:0] exp_s);
    rd_en   = 1'b1;
    rd_addr = addr;
    rd_live = live;
    exp_w_q.push_back(exp_w);
    exp_s_q.push_back(exp_s);
    tick(1);
    rd_en   = 1'b0;
  endtask

  // Response monitor: latency check plus scoreboard pop, away from posedge.
  always @(negedge clk) begin
    if (!rst) begin
      rd_en_prev = 1'b0;
    end else begin
      if (rd_en_prev || rd_valid_w || rd_valid_s) begin
        check_val("rd_valid_lat_w", 32'(rd_valid_w), 32'(rd_en_prev));
        check_val("rd_valid_lat_s", 32'(rd_valid_s), 32'(rd_en_prev));
      end
      if (rd_valid_w) begin
        if (exp_w_q.size() > 0 && exp_s_q.size() > 0) begin
          logic [7:0] ew, es;
          ew = exp_w_q.pop_front();
          es = exp_s_q.pop_front();
          $display("READ got w=%0h s=%0h exp w=%0h s=%0h", rd_data_w, rd_data_s, ew, es);
          check_val("rd_data_w", 32'(rd_data_w), 32'(ew));
          check_val("rd_data_s", 32'(rd_data_s), 32'(es));
          obs_q.push_back(rd_data_w);
        end else begin
          check_val("sb_depth", 32'(exp_w_q.size()), 1);
        end
      end
      rd_en_prev = rd_en;
    end
  end

  initial begin
    int cpi_x100;
    rst = 1'b0; en = 1'b0; retire = '0; evt = '0; clr = 1'b0; snap = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    rd_live = 1'b0; ovf_mask = '0;
    tick(2);
    // Reset state
    check_val("rst_rd_data", 32'(rd_data_w), 0);
    check_val("rst_rd_valid", 32'(rd_valid_w), 0);
    check_val("rst_ovf", 32'(ovf_w), 0);
    check_val("rst_irq", 32'(irq_w), 0);
    rst = 1'b1;

    // Basic counting: 40 enabled cycles, retire 1, five evt0 pulses
    for (int i = 0; i < 40; i++) begin
      en = 1'b1; retire = 2'd1; evt = (i % 8 == 0) ? 4'b0001 : 4'b0000;
      tick(1);
    end
    en = 1'b0; retire = '0; evt = '0;
    do_read(3'd0, 1'b1, 8'd40, 8'd40);
    do_read(3'd1, 1'b1, 8'd40, 8'd40);
    do_read(3'd2, 1'b1, 8'd5, 8'd5);
    tick(2);
    check_val("basic_ovf", 32'(ovf_w), 0);

    // Multi-retire
    clr = 1'b1; tick(1); clr = 1'b0;
    en = 1'b1;
    retire = 2'd2; tick(10);
    retire = 2'd3; tick(10);
    en = 1'b0; retire = '0;
    do_read(3'd1, 1'b1, 8'd50, 8'd50);
    do_read(3'd0, 1'b1, 8'd20, 8'd20);
    tick(2);
    cpi_x100 = 0;
    if (obs_q.size() >= 2 && obs_q[obs_q.size()-2] != 0)
      cpi_x100 = int'(obs_q[obs_q.size()-1]) * 100 / int'(obs_q[obs_q.size()-2]);
    check_val("cpi_x100", 32'(cpi_x100), 40);

    // Wrap / saturate overflow on counter 0
    ovf_mask = 6'b000001;
    do_preset(3'd0, 8'hFD);
    en = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      check_val("wrap_ovf0_w", 32'(ovf_w[0]), (i >= 3) ? 1 : 0);
      check_val("wrap_ovf0_s", 32'(ovf_s[0]), (i >= 3) ? 1 : 0);
      check_val("wrap_irq_w", 32'(irq_w), (i >= 4) ? 1 : 0);
    end
    en = 1'b0;
    do_read(3'd0, 1'b1, 8'h01, 8'hFF);
    tick(2);

    // Preset clears the flag; run again from FE
    do_preset(3'd0, 8'hFE);
    check_val("preset_clr_ovf_w", 32'(ovf_w), 0);
    check_val("preset_irq_lag_w", 32'(irq_w), 1);
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1);
      check_val("sat_ovf0_s", 32'(ovf_s[0]), (i >= 2) ? 1 : 0);
      check_val("sat_irq_s", 32'(irq_s), (i >= 3) ? 1 : 0);
    end
    en = 1'b0;
    do_read(3'd0, 1'b1, 8'h03, 8'hFF);
    tick(2);
    do_preset(3'd0, 8'h00);
    check_val("sat_preset0_ovf_s", 32'(ovf_s[0]), 0);
    check_val("sat_preset0_irq_lag_s", 32'(irq_s), 1);
    tick(1);
    check_val("sat_preset0_irq_s", 32'(irq_s), 0);
    check_val("sat_preset0_irq_w", 32'(irq_w), 0);

    // Priority and snapshot
    do_preset(3'd3, 8'hFF);
    do_preset(3'd2, 8'd7);
    snap = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd100;
    evt = 4'b0001; en = 1'b1;
    tick(1);
    snap = 1'b0; wr_en = 1'b0;
    clr = 1'b1; evt = 4'b1111; en = 1'b1;
    // Live read in the clear cycle returns the pre-clear value
    rd_en = 1'b1; rd_addr = 3'd2; rd_live = 1'b1;
    exp_w_q.push_back(8'd100); exp_s_q.push_back(8'd100);
    tick(1);
    rd_en = 1'b0; clr = 1'b0; evt = '0; en = 1'b0;
    check_val("clr_ovf_w", 32'(ovf_w), 0);
    check_val("clr_ovf_s", 32'(ovf_s), 0);
    do_read(3'd2, 1'b0, 8'd7, 8'd7);
    do_read(3'd1, 1'b0, 8'd50, 8'd50);
    do_read(3'd3, 1'b0, 8'hFF, 8'hFF);
    do_read(3'd0, 1'b0, 8'd0, 8'd0);
    do_read(3'd2, 1'b1, 8'd0, 8'd0);
    do_read(3'd1, 1'b1, 8'd0, 8'd0);
    do_read(3'd3, 1'b1, 8'd0, 8'd0);
    tick(2);

    // Freeze, ignored out-of-range presets, out-of-range reads
    en = 1'b1; retire = 2'd1; evt = 4'b1111;
    tick(3);
    en = 1'b0; retire = 2'd3;
    for (int i = 0; i < 10; i++) begin
      evt = (i % 2 == 0) ? 4'b1111 : 4'b0101;
      tick(1);
    end
    evt = '0; retire = '0;
    do_preset(3'd7, 8'h55);
    do_preset(3'd6, 8'h55);
    do_read(3'd6, 1'b1, 8'd0, 8'd0);
    do_read(3'd7, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 6; i++) begin
      do_read(3'(i), 1'b1, 8'd3, 8'd3);
    end
    tick(2);

    // Async reset mid-cycle with live overflow/irq state
    ovf_mask = 6'b000100;
    do_preset(3'd2, 8'hFF);
    en = 1'b1; evt = 4'b0001;
    tick(1);
    en = 1'b0; evt = '0;
    tick(1);
    check_val("pre_rst_ovf_w", 32'(ovf_w), 32'h4);
    check_val("pre_rst_irq_s", 32'(irq_s), 1);
    check_val("pre_rst_rd_data_w", 32'(rd_data_w), 3);
    en = 1'b1;
    #2 rst = 1'b0;
    #1;
    check_val("arst_rd_data_w", 32'(rd_data_w), 0);
    check_val("arst_rd_valid_w", 32'(rd_valid_w), 0);
    check_val("arst_ovf_w", 32'(ovf_w), 0);
    check_val("arst_ovf_s", 32'(ovf_s), 0);
    check_val("arst_irq_w", 32'(irq_w), 0);
    check_val("arst_irq_s", 32'(irq_s), 0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick(1);
    en = 1'b0;
    do_read(3'd0, 1'b1, 8'd1, 8'd1);
    do_read(3'd2, 1'b0, 8'd0, 8'd0);
    tick(3);

    check_val("sb_left", 32'(exp_w_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
